// File: rtl/clk_divider_prog_if.sv
// Control and status bundle for the programmable clock divider.
// The master side programs the divider; the slave side is the divider itself.
interface clk_divider_prog_if #(
    parameter int unsigned DIV_W = 32
);
    logic             enable;
    logic             div_load;
    logic [DIV_W-1:0] div_value;
    logic             mode_value;
    logic             clk;
    logic             tick;
    logic [DIV_W-1:0] cur_div;
    logic             pending;

    modport master (
        output enable, div_load, div_value, mode_value,
        input  clk, tick, cur_div, pending
    );

    modport slave (
        input  enable, div_load, div_value, mode_value,
        output clk, tick, cur_div, pending
    );
endinterface

// File: rtl/clk_divider_prog.sv
// Runtime-programmable clock divider / tick generator clocked by out_clk.
// New divisor/mode settings wait in a shadow register until a period boundary.
module clk_divider_prog #(
    parameter int unsigned      DIV_W        = 32,
    parameter logic [DIV_W-1:0] DEFAULT_DIV  = DIV_W'(25000000),
    parameter bit               DEFAULT_MODE = 1'b0
) (
    input  logic              out_clk,
    input  logic              reset_n,
    clk_divider_prog_if.slave bus
);

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    // A divisor of zero has no meaningful period, so it is promoted to one.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    logic [DIV_W-1:0] count_q,   count_d;
    logic [DIV_W-1:0] act_div_q, act_div_d;
    mode_e            act_mode_q, act_mode_d;
    logic [DIV_W-1:0] sh_div_q,  sh_div_d;
    mode_e            sh_mode_q,  sh_mode_d;
    logic             pending_q, pending_d;
    logic             clk_q,     clk_d;
    logic             tick_q,    tick_d;

    logic [DIV_W-1:0] ld_div;
    mode_e            ld_mode;
    logic             tc;

    assign ld_div  = clamp_div(bus.div_value);
    assign ld_mode = mode_e'(bus.mode_value);
    assign tc      = bus.enable && (count_q == (act_div_q - ONE));

    always_comb begin
        count_d    = count_q;
        act_div_d  = act_div_q;
        act_mode_d = act_mode_q;
        sh_div_d   = sh_div_q;
        sh_mode_d  = sh_mode_q;
        pending_d  = pending_q;
        clk_d      = clk_q;
        tick_d     = 1'b0;

        if (bus.div_load) begin
            sh_div_d  = ld_div;
            sh_mode_d = ld_mode;
        end

        if (!bus.enable) begin
            // Frozen: a load has no period boundary to wait for, so it lands now.
            if (bus.div_load) begin
                act_div_d  = ld_div;
                act_mode_d = ld_mode;
                count_d    = '0;
                pending_d  = 1'b0;
                clk_d      = 1'b0;
            end else if (act_mode_q == MODE_PULSE) begin
                clk_d = 1'b0;
            end
        end else if (tc) begin
            count_d   = '0;
            tick_d    = 1'b1;
            pending_d = 1'b0;
            if (bus.div_load) begin
                act_div_d  = ld_div;
                act_mode_d = ld_mode;
            end else if (pending_q) begin
                act_div_d  = sh_div_q;
                act_mode_d = sh_mode_q;
            end

            // A mode switch restarts clk low so no partial pulse escapes.
            if (act_mode_d != act_mode_q) begin
                clk_d = 1'b0;
            end else if (act_mode_d == MODE_PULSE) begin
                clk_d = 1'b1;
            end else begin
                clk_d = ~clk_q;
            end
        end else begin
            count_d = count_q + ONE;
            if (bus.div_load) begin
                pending_d = 1'b1;
            end
            if (act_mode_q == MODE_PULSE) begin
                clk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge out_clk) begin
        if (!reset_n) begin
            count_q    <= '0;
            act_div_q  <= DEFAULT_DIV;
            act_mode_q <= mode_e'(DEFAULT_MODE);
            sh_div_q   <= '0;
            sh_mode_q  <= MODE_TOGGLE;
            pending_q  <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            count_q    <= count_d;
            act_div_q  <= act_div_d;
            act_mode_q <= act_mode_d;
            sh_div_q   <= sh_div_d;
            sh_mode_q  <= sh_mode_d;
            pending_q  <= pending_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
        end
    end

    assign bus.clk     = clk_q;
    assign bus.tick    = tick_q;
    assign bus.cur_div = act_div_q;
    assign bus.pending = pending_q;

endmodule
